// File: rtl/hazard_pkg.sv
// Shared constants, FSM state type and width helper for the
// hazard and forwarding controller.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // A latency of 2 still needs a 1-bit counter to hold zero.
   function automatic int cnt_width(input int lat);
      return (lat > 2) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Bypass select for one EX source operand: MEM beats WB,
// and x0 never forwards.
module fwd_src_sel
   import hazard_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rd_mem,
   input  logic [ADDR_W-1:0] rd_wb,
   input  logic              reg_write_mem,
   input  logic              reg_write_wb,
   output logic [1:0]        sel
);

   logic hit_mem;
   logic hit_wb;

   assign hit_mem = reg_write_mem && (rd_mem != '0) && (rs == rd_mem);
   assign hit_wb  = reg_write_wb  && (rd_wb  != '0) && (rs == rd_wb);

   always_comb begin
      sel = FWD_RF;
      if (hit_mem)
         sel = FWD_MEM;
      else if (hit_wb)
         sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: operand bypass selects, load-use
// and branch bubbles, mul/div stall FSM and stall counter.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ex,
   input  logic [REG_ADDR_W-1:0]         rd_ex,
   input  logic [REG_ADDR_W-1:0]         rd_mem,
   input  logic [REG_ADDR_W-1:0]         rd_wb,
   input  logic                          MemRead_ex,
   input  logic                          RegWrite_mem,
   input  logic                          RegWrite_wb,
   input  logic                          muldiv_start_ex,
   input  logic                          branch_taken_ex,
   output logic [NUM_SRC*2-1:0]          fwd_sel,
   output logic                          stall_if,
   output logic                          stall_id,
   output logic                          stall_ex,
   output logic                          flush_id,
   output logic                          flush_ex,
   output logic                          muldiv_done,
   output logic [CNT_W-1:0]              stall_cycles
);

   localparam int CW = cnt_width(MULDIV_LAT);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [NUM_SRC*2-1:0] fwd_raw;
   logic            load_use;
   logic            md_stall;
   logic            md_last;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_sel #(
         .ADDR_W(REG_ADDR_W)
      ) u_sel (
         .rs           (rs_ex[i*REG_ADDR_W +: REG_ADDR_W]),
         .rd_mem       (rd_mem),
         .rd_wb        (rd_wb),
         .reg_write_mem(RegWrite_mem),
         .reg_write_wb (RegWrite_wb),
         .sel          (fwd_raw[i*2 +: 2])
      );
   end

   always_comb begin
      load_use = 1'b0;
      if (MemRead_ex && (rd_ex != '0)) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_id[i*REG_ADDR_W +: REG_ADDR_W] == rd_ex)
               load_use = 1'b1;
         end
      end
   end

   assign md_stall = ((state == IDLE) && muldiv_start_ex)
                  || ((state == BUSY) && (cnt != '0));
   assign md_last  = (state == BUSY) && (cnt == '0);

   always_comb begin
      fwd_sel     = '0;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      muldiv_done = 1'b0;
      if (!reset) begin
         fwd_sel     = fwd_raw;
         muldiv_done = md_last;
         // A discarded ID instruction cannot cause a load-use stall.
         if (md_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
         end else if (branch_taken_ex) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
         end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (muldiv_start_ex) begin
                  state <= BUSY;
                  cnt   <= CW'(MULDIV_LAT - 2);
               end
            end
            BUSY: begin
               if (cnt == '0)
                  state <= IDLE;
               else
                  cnt <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cycles <= '0;
      else if (stall_if && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 1'b1;
   end

endmodule
